cold_room_ctrl: RTL



---
 rtl/cold_room_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/cold_room_ctrl.sv
// ---------------------------------------------------------------------------
// cold_room_ctrl
//
// Thermostat controller for the cold-storage room. Sits directly behind the
// DHT11 reader: each rising edge of data_ready captures one temperature /
// humidity sample. The FSM drives the compressor with hysteresis
// (SET_HI / SET_LO). Minimum OFF and ON dwell timers, counted in 1 s ticks,
// protect the compressor from short-cycling. The block enters FAULT when
// no sample has arrived for STALE_S seconds.
//
// Ports
//   clk          in   system clock (single domain)
//   rst_n        in   asynchronous active-low reset
//   en           in   controller enable; low forces WAIT and clears timers
//   temperature  in   8-bit unsigned deg C from the reader
//   humidity     in   8-bit unsigned %RH from the reader
//   data_ready   in   reader strobe; the rising edge marks a new sample
//   compressor   out  compressor relay drive (state == COOL)
//   fan          out  evaporator fan: compressor, or humidity >= HUM_HI
//   alarm        out  FAULT state, or temperature >= ALARM_T
//   state_o      out  FSM state: WAIT=0, OFF=1, COOL=2, FAULT=3
// ---------------------------------------------------------------------------
module cold_room_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 1_000_000,
    parameter logic [7:0]  SET_HI        = 8'd6,
    parameter logic [7:0]  SET_LO        = 8'd2,
    parameter logic [7:0]  ALARM_T       = 8'd12,
    parameter logic [7:0]  HUM_HI        = 8'd90,
    parameter int unsigned MIN_OFF_S     = 180,
    parameter int unsigned MIN_ON_S      = 60,
    parameter int unsigned STALE_S       = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] temperature,
    input  logic [7:0] humidity,
    input  logic       data_ready,
    output logic       compressor,
    output logic       fan,
    output logic       alarm,
    output logic [1:0] state_o
);

    localparam logic [1:0] ST_WAIT  = 2'd0;
    localparam logic [1:0] ST_OFF   = 2'd1;
    localparam logic [1:0] ST_COOL  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [15:0]   MIN_OFF   = 16'(MIN_OFF_S);
    localparam logic [15:0]   MIN_ON    = 16'(MIN_ON_S);
    localparam logic [7:0]    STALE_LIM = 8'(STALE_S);

    logic          r_dr_q;
    logic [7:0]    r_temp_q;
    logic [7:0]    r_hum_q;
    logic          r_valid;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_run_s;
    logic [7:0]    r_stale_s;
    logic [1:0]    r_state;
    logic          r_compressor;
    logic          r_fan;
    logic          r_alarm;

    logic          w_new_s;
    logic          w_tick;
    logic          w_stale_exp;
    logic [1:0]    w_state_next;
    logic          w_comp_next;
    logic          w_fan_next;
    logic          w_alarm_next;

    assign w_new_s = data_ready & ~r_dr_q;
    assign w_tick  = en & (r_presc == PRESC_MAX);

    // A sample arriving in the very cycle the stale limit is seen wins:
    // the counter is being cleared, so it must not also trip FAULT.
    assign w_stale_exp = (r_stale_s >= STALE_LIM) & ~w_new_s;

    // Next-state logic. Decisions use the registered sample, so a sample
    // captured at edge N influences the state at edge N+1.
    always_comb begin
        w_state_next = r_state;
        if (!en) begin
            w_state_next = ST_WAIT;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_valid)
                        w_state_next = ST_OFF;
                end
                ST_OFF: begin
                    if (w_stale_exp)
                        w_state_next = ST_FAULT;
                    else if ((r_temp_q >= SET_HI) && (r_run_s >= MIN_OFF))
                        w_state_next = ST_COOL;
                end
                ST_COOL: begin
                    if (w_stale_exp)
                        w_state_next = ST_FAULT;
                    else if ((r_temp_q <= SET_LO) && (r_run_s >= MIN_ON))
                        w_state_next = ST_OFF;
                end
                default: begin
                    // FAULT: any fresh sample restarts in OFF, which also
                    // restarts the minimum-off timer before cooling resumes.
                    if (w_new_s)
                        w_state_next = ST_OFF;
                end
            endcase
        end
    end

    // Outputs are registered from the next state, so they change on the
    // same edge as state_o.
    always_comb begin
        w_comp_next  = en & (w_state_next == ST_COOL);
        w_fan_next   = w_comp_next | (en & r_valid & (r_hum_q >= HUM_HI));
        w_alarm_next = (en & (w_state_next == ST_FAULT)) |
                       (en & r_valid & (r_temp_q >= ALARM_T));
    end

    // Sample capture. The edge detector keeps tracking data_ready while
    // disabled, so a strobe held across re-enable does not count twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dr_q   <= 1'b0;
            r_temp_q <= 8'd0;
            r_hum_q  <= 8'd0;
            r_valid  <= 1'b0;
        end else begin
            r_dr_q <= data_ready;
            if (w_new_s) begin
                r_temp_q <= temperature;
                r_hum_q  <= humidity;
            end
            if (!en)
                r_valid <= 1'b0;
            else if (w_new_s)
                r_valid <= 1'b1;
        end
    end

    // Second prescaler and the two second-counters. The prescaler is
    // free-running while enabled and is not re-phased on state changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_run_s   <= 16'd0;
            r_stale_s <= 8'd0;
        end else if (!en) begin
            r_presc   <= '0;
            r_run_s   <= 16'd0;
            r_stale_s <= 8'd0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;

            if (w_state_next != r_state)
                r_run_s <= 16'd0;
            else if (w_tick && (r_run_s != 16'hFFFF))
                r_run_s <= r_run_s + 16'd1;

            if (w_new_s)
                r_stale_s <= 8'd0;
            else if (w_tick && (r_stale_s != 8'hFF))
                r_stale_s <= r_stale_s + 8'd1;
        end
    end

    // State and output registers; reset drops the compressor immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_WAIT;
            r_compressor <= 1'b0;
            r_fan        <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_compressor <= w_comp_next;
            r_fan        <= w_fan_next;
            r_alarm      <= w_alarm_next;
        end
    end

    assign compressor = r_compressor;
    assign fan        = r_fan;
    assign alarm      = r_alarm;
    assign state_o    = r_state;

endmodule
